// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM state encoding and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits, paced by en.
// Parity bit and PARITY state are compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

  uart_tx_state_t         state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`else
  logic                   unused_parity_odd;
  assign unused_parity_odd = 1'(PARITY_ODD);
`endif

  // Next-state and registered-output logic; every bit transition waits for en.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = UART_IDLE_LEVEL;
        if (valid && ready_q) begin
          shift_d    = data;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d      = (^data) ^ 1'(PARITY_ODD);
`endif
          ready_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (en) begin
          tx_d    = UART_START_LEVEL;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (en) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = BIT_CNT_W'(1);
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (en) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
            tx_d       = par_q;
            state_d    = ST_PARITY;
`else
            tx_d       = UART_IDLE_LEVEL;
            stop_cnt_d = 1'b0;
            state_d    = ST_STOP;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (en) begin
          tx_d       = UART_IDLE_LEVEL;
          stop_cnt_d = 1'b0;
          state_d    = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (en) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        tx_d    = UART_IDLE_LEVEL;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset abandons any frame in flight and returns the line high at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= UART_IDLE_LEVEL;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side serializer for the UART path. It accepts one parallel data word per valid/ready handshake and shifts it out on `tx` as an asynchronous serial frame: start bit, LSB-first data bits, optional parity bit, then stop bits. Bit timing comes from the single-cycle baud enable pulse produced by the upstream clock divider. The block itself contains no baud counter.

## Interface
- `DATA_BITS`, default 8: data bits per frame; legal range 5–9.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Used only when parity is compiled in.
- `clk` input, 1 bit: system clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `en` input, 1 bit: baud enable from the divider. One `clk` cycle wide, one pulse per bit period.
- `data` input, `DATA_BITS` bits: word to send. Sampled only on handshake.
- `valid` input, 1 bit: upstream offers `data`.
- `ready` output, 1 bit: block can accept a word. High only in IDLE.
- `tx` output, 1 bit: serial line, registered. Idle level is 1.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse when the final stop bit completes.

## Operation
- States: IDLE, SYNC, START, DATA, PARITY, STOP.
- State advances only on cycles where `en`=1. The exception is IDLE→SYNC, which is driven by the handshake.
- IDLE:
  - `tx`=1, `ready`=1.
  - On `valid`&`ready`, latch `data` into the shift register, clear the counters, and go to SYNC.
  - An `en` pulse in the same cycle as the handshake is ignored.
- SYNC: on `en`, set `tx`←0 (start bit) and go to START. This aligns the start bit to a baud boundary.
- START: on `en`, set `tx`←shift[0], shift right, set bit counter←1, and go to DATA.
- DATA: on `en`:
  - If bit counter=`DATA_BITS`: go to PARITY with `tx`←parity bit when parity is compiled in; otherwise go to STOP with `tx`←1.
  - Otherwise: `tx`←shift[0], shift right, increment the counter.
- PARITY: on `en`, set `tx`←1, clear the stop counter, and go to STOP.
- STOP: on `en`:
  - If stop counter=`STOP_BITS`−1: go to IDLE and pulse `done` for one cycle.
  - Otherwise: increment the stop counter.
- Parity bit = XOR of the latched data bits, inverted when `PARITY_ODD`=1. Compute it at latch time and hold it in a register.
- Counter widths: bit counter is $clog2(`DATA_BITS`+1) bits; stop counter is 1 bit. Counters never wrap within a frame.
- `valid` while busy: ignored. The upstream holds `data` until it sees `ready`.
- `en` in IDLE: ignored. `tx` stays 1.
- Reset, including mid-frame: on the next edge, state=IDLE, `tx`=1, `ready`=1, `busy`=0, `done`=0, and shift register and counters are cleared. A partially sent frame is abandoned and the line returns high immediately.

## Timing
- Reset values: `tx`=1, `ready`=1, `busy`=0, `done`=0.
- Handshake:
  - Acceptance happens in cycle A.
  - `ready` and `busy` change at the edge ending cycle A.
  - `ready`=0 from cycle A+1.
- Each bit is held for exactly one `en` period. `tx` changes on the edge at which `en`=1 is sampled.
- Frame timing, with k-th `en` meaning the k-th pulse after acceptance:
  - Start bit is driven at the 1st `en`.
  - Data bit i is driven at the (i+2)-th `en`.
  - `done` and `ready` assert on the cycle after the `en` that ends the last stop bit.
- 8N1 frame: `done` follows the 11th `en` after acceptance.
- Back-to-back: a new word can be accepted in the first cycle `ready`=1. The minimum idle gap on the line is then one `en` period (the SYNC wait).

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state and the parity register exist.
  - Frame is start + `DATA_BITS` + parity + `STOP_BITS`.
- `UART_TX_PARITY_EN` undefined:
  - PARITY state and the parity logic are absent; `PARITY_ODD` is unused.
  - DATA goes directly to STOP.
  - Frame is start + `DATA_BITS` + `STOP_BITS`.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum `uart_tx_state_t`;
  - constants `UART_IDLE_LEVEL`=1 and `UART_START_LEVEL`=0.
- Single module, no sub-module. The shift register, counters and FSM are small enough to stay flat. The `en` source stays external, the divider instantiated by the top level.

## Test plan
- **Basic 8N1 frame.** Macro off, 8N1, `en` every 4 cycles, send 0x55 → `tx` = 0,1,0,1,0,1,0,1,0,1, each value held 4 cycles. `done` pulses once after the 11th `en`; `ready` returns to 1 in the same cycle.
- **Parity values.** Macro on, send 0xA5 → parity bit 0 with `PARITY_ODD`=0 and 1 with `PARITY_ODD`=1. Send 0x07 with even parity → parity bit 1.
- **Two stop bits.** `STOP_BITS`=2, send 0x00 → 9 low bit periods, 2 high bit periods, `done` after the 12th `en`.
- **Handshake edge cases.**
  - Hold `valid`=1 with new data during a frame → not accepted until `ready`.
  - `en` coincident with acceptance → start bit begins at the next `en`, not the coincident one.
- **Reset mid-frame.** Assert `rst` during data bit 3 → `tx`=1, `ready`=1, `busy`=0 on the next edge. No `done` pulse. The next frame is sent correctly.
- **Back-to-back words.** Send 0x3C and 0xC3 with `valid` held high → both frames correct, exactly one `en` period of idle-high between them.
